// File: rtl/bist_seq_controller.sv
// Sequences power-on BIST (with bounded retries and a timeout) before cycling equations in NORMAL.
// All outputs come straight from flops; reset is asynchronous and forces every output to its idle value.
module bist_seq_controller #(
  parameter int NUM_EQ        = 4,
  parameter int CYCLES_PER_EQ = 8,
  parameter int BIST_TIMEOUT  = 32,
  parameter int MAX_RETRY     = 1,
  localparam int EQ_W  = (NUM_EQ > 1) ? $clog2(NUM_EQ) : 1,
  localparam int CNT_W = (CYCLES_PER_EQ > 1) ? $clog2(CYCLES_PER_EQ) : 1,
  localparam int TO_W  = $clog2(BIST_TIMEOUT + 1),
  localparam int RT_W  = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             rerun_bist,
  input  logic             bist_active,
  input  logic             bist_pass,
  output logic             start_bist,
  output logic             normal_active,
  output logic [EQ_W-1:0]  sel_eq,
  output logic [CNT_W-1:0] cycle_count,
  output logic             bist_fail,
  output logic [RT_W-1:0]  retry_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BIST_REQ  = 3'd1,
    BIST_WAIT = 3'd2,
    READY     = 3'd3,
    NORMAL    = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             act_q;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_cnt_inc;
  logic             done, timeout, retry_ok;

  assign to_cnt_inc = to_cnt + 1'b1;
  assign done       = act_q & ~bist_active;
  assign timeout    = (to_cnt_inc == TO_W'(BIST_TIMEOUT));
  assign retry_ok   = (retry_count < RT_W'(MAX_RETRY));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = BIST_REQ;
      BIST_REQ:  state_d = BIST_WAIT;
      BIST_WAIT: begin
        // A completion seen on the timeout cycle still counts as completion.
        if (done && bist_pass)  state_d = READY;
        else if (done || timeout) state_d = retry_ok ? BIST_REQ : FAIL;
      end
      READY: begin
        if (rerun_bist) state_d = BIST_REQ;
        else if (start) state_d = NORMAL;
      end
      NORMAL:    if (stop) state_d = READY;
      FAIL:      state_d = FAIL;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      act_q         <= 1'b0;
      to_cnt        <= '0;
      retry_count   <= '0;
      sel_eq        <= '0;
      cycle_count   <= '0;
      start_bist    <= 1'b0;
      normal_active <= 1'b0;
      bist_fail     <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= (state_d == BIST_REQ) ? 1'b0 : bist_active;

      if (state_q == BIST_REQ)                          to_cnt <= '0;
      else if (state_q == BIST_WAIT && !timeout)        to_cnt <= to_cnt_inc;

      if (state_q == READY && rerun_bist)
        retry_count <= '0;
      else if (state_q == BIST_WAIT && state_d == BIST_REQ && retry_ok)
        retry_count <= retry_count + 1'b1;

      // Counters only run while staying in NORMAL, so entry and exit both see zeros.
      if (state_q == NORMAL && state_d == NORMAL) begin
        if (cycle_count == CNT_W'(CYCLES_PER_EQ - 1)) begin
          cycle_count <= '0;
          sel_eq      <= (sel_eq == EQ_W'(NUM_EQ - 1)) ? '0 : sel_eq + 1'b1;
        end else begin
          cycle_count <= cycle_count + 1'b1;
        end
      end else begin
        cycle_count <= '0;
        sel_eq      <= '0;
      end

      start_bist    <= (state_d == BIST_REQ);
      normal_active <= (state_d == NORMAL);
      bist_fail     <= (state_d == FAIL);
    end
  end

  assign state = state_q;

endmodule
